// File: rtl/spi_vec_regs_if.sv
// Bus bundle for spi_vec_regs: raw SPI pins, the frame-sync strobe and the
// live register / status outputs. Master side drives SPI and strobe.
interface spi_vec_regs_if #(
    parameter int NREGS = 6,
    parameter int DW    = 18
);
    logic                  i_sclk;
    logic                  i_ss_n;
    logic                  i_mosi;
    logic                  load_if_ready;
    logic [NREGS*DW-1:0]   o_regs;
    logic                  o_pending;
    logic                  o_loaded;
    logic                  o_frame_err;

    modport master (
        output i_sclk, i_ss_n, i_mosi, load_if_ready,
        input  o_regs, o_pending, o_loaded, o_frame_err
    );

    modport slave (
        input  i_sclk, i_ss_n, i_mosi, load_if_ready,
        output o_regs, o_pending, o_loaded, o_frame_err
    );
endinterface

// File: rtl/spi_vec_regs.sv
// SPI-loaded, double-buffered vector register bank. Frames write a
// contiguous run of registers into staging; dirty entries are copied to the
// live outputs only after the frame closes and either the frame-sync strobe
// or the frame's immediate-apply flag allows it.
module spi_vec_regs #(
    parameter int                  NREGS        = 6,
    parameter int                  DW           = 18,
    parameter logic [NREGS*DW-1:0] RESET_VALUES = {18'h00300, 18'h00300, 18'h00000,
                                                   18'h00200, 18'h3FF00, 18'h00000}
) (
    input  logic           clk,
    input  logic           reset,
    spi_vec_regs_if.slave  bus
);
    localparam int              IW        = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int              CW        = $clog2(DW);
    localparam logic [7:0]      NREGS8    = 8'(NREGS);
    localparam logic [CW-1:0]   LAST_HDR  = CW'(7);
    localparam logic [CW-1:0]   LAST_WORD = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    logic [2:0]          sclk_sync_q, sclk_sync_d;
    logic [2:0]          ss_sync_q,   ss_sync_d;
    logic [1:0]          mosi_sync_q, mosi_sync_d;
    state_t              state_q,     state_d;
    logic [CW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DW-1:0]       shift_q,     shift_d;
    logic [7:0]          idx_q,       idx_d;
    logic                imm_q,       imm_d;
    logic [NREGS*DW-1:0] stg_q,       stg_d;
    logic [NREGS*DW-1:0] live_q,      live_d;
    logic [NREGS-1:0]    dirty_q,     dirty_d;
    logic                pending_q,   pending_d;
    logic                apply_now_q, apply_now_d;
    logic                loaded_q,    loaded_d;
    logic                frame_err_q, frame_err_d;

    logic                sclk_rise, ss_fall, ss_rise, frame_active, mosi_s;
    logic [IW-1:0]       wr_idx;

    // Edge detects use the two oldest synchroniser taps. Frame-active uses
    // the oldest ss_n tap so the commit cycle itself still counts as inside
    // the frame, which keeps apply off until commit has landed.
    assign sclk_rise    = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ss_fall      = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise      = ~ss_sync_q[2] & ss_sync_q[1];
    assign frame_active = ~ss_sync_q[2];
    assign mosi_s       = mosi_sync_q[1];
    assign wr_idx       = idx_q[IW-1:0];

    assign bus.o_regs      = live_q;
    assign bus.o_pending   = pending_q;
    assign bus.o_loaded    = loaded_q;
    assign bus.o_frame_err = frame_err_q;

    // Next-state: synchronisers, header/word FSM, staging writes, commit, apply.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.i_sclk};
        ss_sync_d   = {ss_sync_q[1:0], bus.i_ss_n};
        mosi_sync_d = {mosi_sync_q[0], bus.i_mosi};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        imm_d       = imm_q;
        stg_d       = stg_q;
        live_d      = live_q;
        dirty_d     = dirty_q;
        pending_d   = pending_q;
        apply_now_d = apply_now_q;
        loaded_d    = 1'b0;
        frame_err_d = frame_err_q;

        if (ss_fall) begin
            // New frame: staging and dirty bits survive so frames can merge.
            state_d     = HDR;
            bit_cnt_d   = '0;
            idx_d       = '0;
            imm_d       = 1'b0;
            frame_err_d = 1'b0;
        end else if (ss_rise) begin
            // Commit: any leftover bits are a truncated header/word.
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (state_q != IDLE && bit_cnt_q != '0)
                frame_err_d = 1'b1;
            if (|dirty_q) begin
                pending_d = 1'b1;
                if (imm_q)
                    apply_now_d = 1'b1;
            end
        end else if (frame_active && sclk_rise && state_q != IDLE) begin
            shift_d = {shift_q[DW-2:0], mosi_s};
            case (state_q)
                HDR: begin
                    if (bit_cnt_q == LAST_HDR) begin
                        imm_d     = shift_d[7];
                        idx_d     = {1'b0, shift_d[6:0]};
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == LAST_WORD) begin
                        bit_cnt_d = '0;
                        // Past the last register: drop the word, no wrap.
                        if (idx_q < NREGS8) begin
                            stg_d[(NREGS-1-int'(wr_idx))*DW +: DW] = shift_d;
                            dirty_d[wr_idx] = 1'b1;
                            idx_d = idx_q + 8'd1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Apply is exclusive with any staging write because it needs the
        // frame closed; it uses pre-commit pending in a commit cycle.
        if (pending_q && !frame_active && (bus.load_if_ready || apply_now_q)) begin
            for (int i = 0; i < NREGS; i++)
                if (dirty_q[i])
                    live_d[(NREGS-1-i)*DW +: DW] = stg_q[(NREGS-1-i)*DW +: DW];
            dirty_d     = '0;
            pending_d   = 1'b0;
            apply_now_d = 1'b0;
            loaded_d    = 1'b1;
        end
    end

    // State register with asynchronous reset to the documented idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            imm_q       <= 1'b0;
            stg_q       <= RESET_VALUES;
            live_q      <= RESET_VALUES;
            dirty_q     <= '0;
            pending_q   <= 1'b0;
            apply_now_q <= 1'b0;
            loaded_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            imm_q       <= imm_d;
            stg_q       <= stg_d;
            live_q      <= live_d;
            dirty_q     <= dirty_d;
            pending_q   <= pending_d;
            apply_now_q <= apply_now_d;
            loaded_q    <= loaded_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_spi_vec_regs.sv
// Bench for spi_vec_regs: vector table, hand-timed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_spi_vec_regs;
    localparam int NREGS = 6;
    localparam int DW    = 18;
    localparam int VW    = NREGS * DW;
    localparam logic [VW-1:0] RV = {18'h00300, 18'h00300, 18'h00000,
                                    18'h00200, 18'h3FF00, 18'h00000};

    typedef logic [5:0][DW-1:0] words_t;

    typedef struct {
        logic [7:0]    hdr;
        int            nw;       // -1: no frame, strobe only
        words_t        w;
        int            xn;       // trailing partial-word bits
        logic          strobe;
        logic          exp_pend;
        logic          exp_err;
        int            exp_loads;
        logic [VW-1:0] exp_regs;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_vec_regs_if #(.NREGS(NREGS), .DW(DW)) bus();
    spi_vec_regs #(.NREGS(NREGS), .DW(DW), .RESET_VALUES(RV)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;
    int load_cnt = 0;

    always @(negedge clk) if (bus.o_loaded === 1'b1) load_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dreg(input int i);
        return bus.o_regs[(NREGS-1-i)*DW +: DW];
    endfunction

    function automatic words_t mkw(input logic [DW-1:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    // ---------------- reference model (frame-level) ----------------
    logic [DW-1:0] m_live [NREGS];
    logic [DW-1:0] m_stg  [NREGS];
    bit            m_dirty[NREGS];
    bit            m_pend, m_err;
    int            m_loads = 0;

    function automatic void m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_live[i]  = RV[(NREGS-1-i)*DW +: DW];
            m_stg[i]   = m_live[i];
            m_dirty[i] = 0;
        end
        m_pend = 0;
        m_err  = 0;
    endfunction

    function automatic logic [VW-1:0] m_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NREGS; i++) v[(NREGS-1-i)*DW +: DW] = m_live[i];
        return v;
    endfunction

    function automatic void m_apply();
        if (!m_pend) return;
        for (int i = 0; i < NREGS; i++) begin
            if (m_dirty[i]) m_live[i] = m_stg[i];
            m_dirty[i] = 0;
        end
        m_pend = 0;
        m_loads++;
    endfunction

    // Returns 1 when the frame asks for (and has data for) immediate apply.
    function automatic bit m_frame(input logic [7:0] hdr, input int hbits, input int nw,
                                   input words_t w, input int xn);
        int idx;
        bit any;
        m_err = 0;
        if (hbits < 8) begin
            m_err = (hbits != 0);
            return 0;
        end
        idx = int'(hdr[6:0]);
        for (int k = 0; k < nw; k++) begin
            if (idx < NREGS) begin
                m_stg[idx] = w[k];
                m_dirty[idx] = 1;
                idx++;
            end else begin
                m_err = 1;
            end
        end
        if (xn != 0) m_err = 1;
        any = 0;
        for (int i = 0; i < NREGS; i++) any |= m_dirty[i];
        if (any) m_pend = 1;
        return any && hdr[7];
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic send_bit(input logic b);
        bus.i_mosi = b;
        repeat (4) @(negedge clk);
        bus.i_sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.i_sclk = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk) bus.load_if_ready = 1'b1;
        @(negedge clk) bus.load_if_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_body(input logic [7:0] hdr, input int hbits, input int nw,
                              input words_t w, input int xn, input logic [31:0] xv,
                              input bit mid_strobe);
        @(negedge clk) bus.i_ss_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 8 - hbits; i--) send_bit(hdr[i]);
        if (mid_strobe) strobe();
        for (int k = 0; k < nw; k++)
            for (int i = DW - 1; i >= 0; i--) send_bit(w[k][i]);
        for (int i = xn - 1; i >= 0; i--) send_bit(xv[i]);
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [7:0] hdr, input int hbits, input int nw,
                             input words_t w, input int xn, input logic [31:0] xv,
                             input bit mid_strobe);
        frame_body(hdr, hbits, nw, w, xn, xv, mid_strobe);
        bus.i_ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " regs"}, bus.o_regs, m_vec());
        chk({tag, " pending"}, VW'(bus.o_pending), VW'(m_pend));
        chk({tag, " frame_err"}, VW'(bus.o_frame_err), VW'(m_err));
        chk({tag, " loads"}, VW'(load_cnt), VW'(m_loads));
    endtask

    vec_t tbl[10];

    initial begin
        int l0;
        words_t z;
        z = '0;

        tbl[0] = '{8'h02, 2, mkw(18'h00400, 18'h3FE00, 0, 0, 0, 0), 0, 1'b0, 1'b1, 1'b0, 0, RV};
        tbl[1] = '{8'h00, -1, z, 0, 1'b1, 1'b0, 1'b0, 1,
                   {18'h00300, 18'h00300, 18'h00400, 18'h3FE00, 18'h3FF00, 18'h00000}};
        tbl[2] = '{8'h80, 6, mkw(18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h6), 0, 1'b0, 1'b0, 1'b0, 1,
                   {18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h6}};
        tbl[3] = '{8'h05, 3, mkw(18'h11111, 18'h22222, 18'h33333, 0, 0, 0), 0, 1'b0, 1'b1, 1'b1, 0,
                   {18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h6}};
        tbl[4] = '{8'h00, -1, z, 0, 1'b1, 1'b0, 1'b1, 1,
                   {18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h11111}};
        tbl[5] = '{8'h01, 1, mkw(18'h00010, 0, 0, 0, 0, 0), 0, 1'b0, 1'b1, 1'b0, 0,
                   {18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h11111}};
        tbl[6] = '{8'h00, 1, mkw(18'h0ABCD, 0, 0, 0, 0, 0), 7, 1'b0, 1'b1, 1'b1, 0,
                   {18'h1, 18'h2, 18'h3, 18'h4, 18'h5, 18'h11111}};
        tbl[7] = '{8'h00, -1, z, 0, 1'b1, 1'b0, 1'b1, 1,
                   {18'h0ABCD, 18'h00010, 18'h3, 18'h4, 18'h5, 18'h11111}};
        tbl[8] = '{8'h80, 0, z, 0, 1'b0, 1'b0, 1'b0, 0,
                   {18'h0ABCD, 18'h00010, 18'h3, 18'h4, 18'h5, 18'h11111}};
        tbl[9] = '{8'h00, -1, z, 0, 1'b1, 1'b0, 1'b0, 0,
                   {18'h0ABCD, 18'h00010, 18'h3, 18'h4, 18'h5, 18'h11111}};

        reset = 1'b1;
        bus.i_sclk = 1'b0; bus.i_ss_n = 1'b1; bus.i_mosi = 1'b0; bus.load_if_ready = 1'b0;
        m_reset();
        #2;
        chk("reset regs", bus.o_regs, RV);
        chk("reset reg0", VW'(dreg(0)), VW'(18'h00300));
        chk("reset reg4", VW'(dreg(4)), VW'(18'h3FF00));
        chk("reset pending", VW'(bus.o_pending), '0);
        chk("reset loaded", VW'(bus.o_loaded), '0);
        chk("reset frame_err", VW'(bus.o_frame_err), '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---------- table vectors ----------
        for (int t = 0; t < 10; t++) begin
            l0 = load_cnt;
            if (tbl[t].nw >= 0) begin
                spi_frame(tbl[t].hdr, 8, tbl[t].nw, tbl[t].w, tbl[t].xn, 32'h55, 1'b0);
                if (m_frame(tbl[t].hdr, 8, tbl[t].nw, tbl[t].w, tbl[t].xn)) m_apply();
            end
            if (tbl[t].strobe) begin
                strobe();
                m_apply();
            end
            chk($sformatf("vec%0d regs", t), bus.o_regs, tbl[t].exp_regs);
            chk($sformatf("vec%0d pending", t), VW'(bus.o_pending), VW'(tbl[t].exp_pend));
            chk($sformatf("vec%0d frame_err", t), VW'(bus.o_frame_err), VW'(tbl[t].exp_err));
            chk($sformatf("vec%0d loads", t), VW'(load_cnt - l0), VW'(tbl[t].exp_loads));
        end

        // ---------- IMM apply lands exactly one cycle after commit ----------
        l0 = load_cnt;
        frame_body(8'h82, 8, 1, mkw(18'h00777, 0, 0, 0, 0, 0), 0, 0, 1'b0);
        bus.i_ss_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("imm commit pending", VW'(bus.o_pending), VW'(1'b1));
        chk("imm commit loaded", VW'(bus.o_loaded), VW'(1'b0));
        chk("imm commit reg2 old", VW'(dreg(2)), VW'(18'h3));
        @(negedge clk);
        chk("imm apply loaded", VW'(bus.o_loaded), VW'(1'b1));
        chk("imm apply reg2", VW'(dreg(2)), VW'(18'h00777));
        @(negedge clk);
        chk("imm single pulse", VW'(load_cnt - l0), VW'(1));
        if (m_frame(8'h82, 8, 1, mkw(18'h00777, 0, 0, 0, 0, 0), 0)) m_apply();
        repeat (3) @(negedge clk);
        check_all("imm");

        // ---------- strobe coincident with commit, nothing pending before ----------
        frame_body(8'h03, 8, 1, mkw(18'h01234, 0, 0, 0, 0, 0), 0, 0, 1'b0);
        bus.i_ss_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.load_if_ready = 1'b1;
        @(negedge clk) bus.load_if_ready = 1'b0;
        repeat (4) @(negedge clk);
        void'(m_frame(8'h03, 8, 1, mkw(18'h01234, 0, 0, 0, 0, 0), 0));
        check_all("coincident");
        strobe();
        m_apply();
        chk("coincident reg3", VW'(dreg(3)), VW'(18'h01234));
        check_all("coincident strobe");

        // ---------- merge with strobe blocked by an active frame ----------
        spi_frame(8'h01, 8, 1, mkw(18'h00100, 0, 0, 0, 0, 0), 0, 0, 1'b0);
        void'(m_frame(8'h01, 8, 1, mkw(18'h00100, 0, 0, 0, 0, 0), 0));
        l0 = load_cnt;
        spi_frame(8'h01, 8, 1, mkw(18'h00200, 0, 0, 0, 0, 0), 0, 0, 1'b1);
        void'(m_frame(8'h01, 8, 1, mkw(18'h00200, 0, 0, 0, 0, 0), 0));
        chk("merge no load", VW'(load_cnt - l0), VW'(0));
        chk("merge reg1 held", VW'(dreg(1)), VW'(18'h00010));
        strobe();
        m_apply();
        chk("merge reg1", VW'(dreg(1)), VW'(18'h00200));
        check_all("merge");

        // ---------- randomized frames vs reference model ----------
        for (int r = 0; r < 25; r++) begin
            logic [7:0] hd;
            int hb, nw, xn;
            words_t w;
            bit ms;
            hb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 8;
            hd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
            nw = (hb == 8) ? int'($urandom_range(0, 6)) : 0;
            for (int k = 0; k < 6; k++) w[k] = 18'($urandom);
            xn = (hb == 8 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : 0;
            ms = 1'($urandom_range(0, 1));
            spi_frame(hd, hb, nw, w, xn, $urandom, ms);
            if (m_frame(hd, hb, nw, w, xn)) m_apply();
            check_all($sformatf("rand%0d frame", r));
            if ($urandom_range(0, 1) == 1) begin
                strobe();
                m_apply();
                check_all($sformatf("rand%0d strobe", r));
            end
        end

        // ---------- asynchronous reset mid-frame, mid-cycle ----------
        @(negedge clk) bus.i_ss_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid reset regs", bus.o_regs, RV);
        chk("mid reset pending", VW'(bus.o_pending), '0);
        chk("mid reset frame_err", VW'(bus.o_frame_err), '0);
        bus.i_ss_n = 1'b1;
        bus.i_sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
        spi_frame(8'h80, 8, 1, mkw(18'h12345, 0, 0, 0, 0, 0), 0, 0, 1'b0);
        if (m_frame(8'h80, 8, 1, mkw(18'h12345, 0, 0, 0, 0, 0), 0)) m_apply();
        chk("post reset reg0", VW'(dreg(0)), VW'(18'h12345));
        check_all("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
